maze_path_player: RTL and testbench
===================================

Name: maze_path_player

Overview:
- Consumer side of the answer stack: after the solver finishes, pops stored moves one per handshake and replays the path from the start cell.
- Emits each move with the resulting (x,y) cell on a valid/ready stream for display/verification logic.
- Sits after the maze solver datapath and reads the answer stack through its pop/dout/empty interface.

Parameters:
- COORD_W, 4, coordinate width; maze is 2^COORD_W × 2^COORD_W.
- START_X, 0, x of start cell loaded on start.
- START_Y, 0, y of start cell loaded on start.
- CNT_W, 8, step counter width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins replay (ignored unless IDLE or DONE).
- ans_empty  in  1  answer stack empty flag.
- ans_dout  in  2  top-of-stack move, valid whenever ans_empty=0.
- ans_pop  out  1  one-cycle pop strobe; stack removes top, new top valid next cycle.
- out_valid  out  1  move/cell record available.
- out_ready  in  1  downstream accepts when out_valid&out_ready.
- out_move  out  2  move being reported.
- out_x  out  COORD_W  x after applying out_move.
- out_y  out  COORD_W  y after applying out_move.
- busy  out  1  high in FETCH/SEND.
- done  out  1  level, high in DONE until start or rst.
- err  out  1  sticky in DONE; set if a move leaves the grid.
- step_count  out  CNT_W  number of accepted records.

Behaviour:
- Move encoding (fixed): 0 → y+1, 1 → x+1, 2 → x−1, 3 → y−1. Moves 1/2 touch x, 0/3 touch y.
- Reset: state IDLE; ans_pop=0, out_valid=0, busy=0, done=0, err=0, step_count=0, out_move=0, out_x=START_X, out_y=START_Y.
- IDLE: on start → cur_x/cur_y=START_X/START_Y, step_count=0, err=0, go FETCH.
- FETCH:
  - If ans_empty=1 → DONE, err=0 (empty path is legal).
  - Else compute next cell in COORD_W+1 bits. If the result is <0 or >2^COORD_W−1 → err=1, DONE, no pop.
  - Else register out_move=ans_dout, out_x/out_y=next cell, assert ans_pop for exactly this one cycle, go SEND.
- SEND:
  - out_valid=1. out_move/out_x/out_y held stable until accepted.
  - On out_valid&out_ready: cur←(out_x,out_y), step_count+1, go FETCH (out_valid drops next cycle).
  - Latency: one accepted record per 2 cycles when out_ready is held high.
- step_count saturates at all-ones; no wrap.
- DONE: done=1, busy=0; start re-enters FETCH as in IDLE (clears done/err/count). ans_pop never asserted in IDLE/DONE.
- Start while busy: ignored.
- rst mid-replay: immediate return to reset values; the stack is not popped in that cycle. Already-popped moves are lost, so the caller must reload the stack.
- ans_pop is never asserted while ans_empty=1.
- out_valid and ans_pop are never high in the same cycle.

Test Plan:
- Reset then start with empty stack → done=1 two cycles after start, err=0, step_count=0, ans_pop never high.
- Stack top-first 1,1,0,0 (start 0,0), out_ready=1 → records (1,1,0),(1,2,0),(0,2,1),(0,2,2); done, step_count=4, four single-cycle ans_pop pulses.
- Same path, out_ready low 5 cycles on the 2nd record → out_move/out_x/out_y stable and no extra pop while stalled; final results unchanged.
- Stack top 3 at start (0,0) → err=1, done=1, no pop, out_valid never high; a new start clears err.
- Pulse rst during SEND of the 2nd record → next cycle out_valid=0, busy=0, step_count=0, out_x=out_y=0; no pop in the reset cycle.
- 15 moves of 1 then one more 1 with COORD_W=4 → x reaches 15; the 16th move sets err, step_count=15.

Source files
------------

// File: rtl/maze_path_player.sv
// Replays a solved maze path: pops moves from the answer stack one at a time,
// walks them from the start cell and streams each (move, x, y) record downstream.
module maze_path_player #(
    parameter int COORD_W = 4,
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               ans_empty,
    input  logic [1:0]         ans_dout,
    output logic               ans_pop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_move,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   step_count
);

    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0] ONE  = SW'(1);
    localparam logic signed [SW-1:0] CMAX = SW'((1 << COORD_W) - 1);
    localparam logic [COORD_W-1:0]   SX   = COORD_W'(START_X);
    localparam logic [COORD_W-1:0]   SY   = COORD_W'(START_Y);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t state, state_nxt;

    logic [COORD_W-1:0]     cur_x, cur_y;
    logic signed [SW-1:0]   nx, ny;
    logic                   oob;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Candidate cell is computed with headroom so both underflow and overflow show up.
    always_comb begin
        nx = $signed({2'b00, cur_x});
        ny = $signed({2'b00, cur_y});
        unique case (ans_dout)
            2'd0: ny = ny + ONE;
            2'd1: nx = nx + ONE;
            2'd2: nx = nx - ONE;
            2'd3: ny = ny - ONE;
            default: ;
        endcase
        oob = nx[SW-1] || ny[SW-1] || (nx > CMAX) || (ny > CMAX);
    end

    always_comb begin
        state_nxt = state;
        ans_pop   = 1'b0;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = FETCH;
            FETCH: begin
                if (ans_empty || oob) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SEND;
                    ans_pop   = !rst;
                end
            end
            SEND: if (out_ready) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid = (state == SEND);
    assign busy      = (state == FETCH) || (state == SEND);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            err        <= 1'b0;
            step_count <= '0;
            out_move   <= 2'd0;
            out_x      <= SX;
            out_y      <= SY;
            cur_x      <= SX;
            cur_y      <= SY;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cur_x      <= SX;
                        cur_y      <= SY;
                        step_count <= '0;
                        err        <= 1'b0;
                    end
                end
                FETCH: begin
                    if (ans_empty) begin
                        err <= 1'b0;
                    end else if (oob) begin
                        err <= 1'b1;
                    end else begin
                        out_move <= ans_dout;
                        out_x    <= nx[COORD_W-1:0];
                        out_y    <= ny[COORD_W-1:0];
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        cur_x      <= out_x;
                        cur_y      <= out_y;
                        step_count <= sat_inc(step_count);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_path_player.sv
// Directed bench for maze_path_player: a stack model feeds moves, a path-walk
// model predicts the record stream, and a per-cycle check compares the DUT.
module tb_maze_path_player;

    localparam int COORD_W = 4;
    localparam int CNT_W   = 8;
    localparam int GMAX    = (1 << COORD_W) - 1;
    localparam int SMAX    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst, start, ans_empty, ans_pop, out_valid, out_ready;
    logic [1:0]         ans_dout, out_move;
    logic [COORD_W-1:0] out_x, out_y;
    logic               busy, done, err;
    logic [CNT_W-1:0]   step_count;

    always #5 clk = ~clk;

    maze_path_player #(.COORD_W(COORD_W), .START_X(0), .START_Y(0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .ans_empty(ans_empty), .ans_dout(ans_dout),
        .ans_pop(ans_pop), .out_valid(out_valid), .out_ready(out_ready), .out_move(out_move),
        .out_x(out_x), .out_y(out_y), .busy(busy), .done(done), .err(err),
        .step_count(step_count)
    );

    // Answer stack: entries n_pop..n_load-1, top at n_pop.
    logic [1:0] stk_mem [0:1023];
    logic [9:0] n_pop, n_load;
    assign ans_empty = (n_pop == n_load);
    assign ans_dout  = stk_mem[n_pop];

    int  vectors = 0, miscompares = 0;
    int  path [0:299];
    int  exp_mv [0:299], exp_x [0:299], exp_y [0:299];
    int  exp_n, exp_err, exp_rd, acc, pops;
    bit  pend_pop, prev_hold, ready_def;
    int  prev_mv, prev_x, prev_y;
    int  stall_at, stall_left;

    task automatic chk(input string nm, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    task automatic load(input int len);
        for (int i = 0; i < len; i++) stk_mem[n_pop + 10'(i)] = 2'(path[i]);
        n_load = n_pop + 10'(len);
    endtask

    // Walk the stacked moves from the start cell until the path ends or leaves the grid.
    task automatic build_model();
        int x, y, nx, ny, m;
        x = 0; y = 0; exp_n = 0; exp_err = 0;
        for (int i = 0; i < int'(n_load - n_pop); i++) begin
            m  = int'(stk_mem[n_pop + 10'(i)]);
            nx = x + ((m == 1) ? 1 : 0) - ((m == 2) ? 1 : 0);
            ny = y + ((m == 0) ? 1 : 0) - ((m == 3) ? 1 : 0);
            if (nx < 0 || nx > GMAX || ny < 0 || ny > GMAX) begin
                exp_err = 1;
                break;
            end
            exp_mv[exp_n] = m; exp_x[exp_n] = nx; exp_y[exp_n] = ny;
            exp_n++;
            x = nx; y = ny;
        end
    endtask

    task automatic check();
        if (prev_hold) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_move", int'(out_move), prev_mv);
            chk("hold_x", int'(out_x), prev_x);
            chk("hold_y", int'(out_y), prev_y);
        end
        chk("valid_and_pop", int'(out_valid & ans_pop), 0);
        chk("busy_and_done", int'(busy & done), 0);
        chk("step_count", int'(step_count), acc);
        if (ans_pop) begin
            chk("pop_when_empty", int'(ans_empty), 0);
            pend_pop = 1'b1;
            pops++;
        end
        out_ready = ready_def;
        prev_hold = 1'b0;
        if (out_valid) begin
            chk("busy_in_send", int'(busy), 1);
            if (exp_rd < exp_n) begin
                chk("rec_move", int'(out_move), exp_mv[exp_rd]);
                chk("rec_x", int'(out_x), exp_x[exp_rd]);
                chk("rec_y", int'(out_y), exp_y[exp_rd]);
            end else begin
                chk("unexpected_record", 1, 0);
            end
            if (exp_rd == stall_at && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end
            if (out_ready) begin
                exp_rd++;
                if (acc < SMAX) acc++;
            end else begin
                prev_hold = 1'b1;
                prev_mv = int'(out_move); prev_x = int'(out_x); prev_y = int'(out_y);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pend_pop) begin
            n_pop = n_pop + 10'd1;
            pend_pop = 1'b0;
        end
        @(negedge clk);
        check();
    endtask

    task automatic do_start();
        build_model();
        acc = 0; exp_rd = 0; pops = 0; prev_hold = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (!done && k < limit) begin
            tick();
            k++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic finish_run(input string tag);
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_err"}, int'(err), exp_err);
        chk({tag, "_count"}, int'(step_count), (exp_n > SMAX) ? SMAX : exp_n);
        chk({tag, "_records"}, exp_rd, exp_n);
        chk({tag, "_pops"}, pops, exp_n);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; ready_def = 1'b1;
        n_pop = '0; n_load = '0; pend_pop = 1'b0; prev_hold = 1'b0;
        exp_n = 0; exp_err = 0; exp_rd = 0; acc = 0; pops = 0;
        stall_at = -1; stall_left = 0;
        prev_mv = 0; prev_x = 0; prev_y = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_pop", int'(ans_pop), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_move", int'(out_move), 0);
        chk("rst_x", int'(out_x), 0);
        chk("rst_y", int'(out_y), 0);

        // Empty path: DONE two cycles after start, no pops.
        load(0);
        do_start();
        chk("empty_done_c1", int'(done), 0);
        tick();
        chk("empty_done_c2", int'(done), 1);
        finish_run("empty");

        // Path 1,1,0,0 with hand-computed records pinning the model.
        path[0] = 1; path[1] = 1; path[2] = 0; path[3] = 0;
        load(4);
        do_start();
        chk("model_n", exp_n, 4);
        chk("model_r1_x", exp_x[1], 2);
        chk("model_r3_mv", exp_mv[3], 0);
        chk("model_r3_y", exp_y[3], 2);
        wait_done(100);
        finish_run("path4");
        chk("path4_x", int'(out_x), 2);
        chk("path4_y", int'(out_y), 2);

        // Same path with the second record stalled for 5 cycles.
        load(4);
        stall_at = 1; stall_left = 5;
        do_start();
        wait_done(100);
        finish_run("stall");
        chk("stall_used", stall_left, 0);
        stall_at = -1;

        // First move steps below y=0: error, no pop, then a fresh start clears it.
        path[0] = 3;
        load(1);
        do_start();
        wait_done(100);
        finish_run("oob_y");
        chk("oob_y_err", int'(err), 1);
        load(0);
        do_start();
        chk("restart_err", int'(err), 0);
        wait_done(100);
        finish_run("restart");

        // Reset while the second record is being offered.
        path[0] = 1; path[1] = 1; path[2] = 0; path[3] = 0;
        load(4);
        stall_at = 1; stall_left = 1000;
        do_start();
        for (int k = 0; k < 50 && !(out_valid && exp_rd == 1); k++) tick();
        chk("rst_mid_reached", int'(out_valid && exp_rd == 1), 1);
        begin
            int p;
            p = pops;
            rst = 1'b1;
            acc = 0; exp_rd = 0; exp_n = 0; prev_hold = 1'b0; stall_left = 0;
            tick();
            rst = 1'b0;
            chk("midrst_valid", int'(out_valid), 0);
            chk("midrst_busy", int'(busy), 0);
            chk("midrst_count", int'(step_count), 0);
            chk("midrst_x", int'(out_x), 0);
            chk("midrst_y", int'(out_y), 0);
            chk("midrst_pops", pops, p);
        end
        stall_at = -1;
        tick();

        // Sixteen +x moves: x reaches 15, the 16th leaves the grid.
        for (int i = 0; i < 16; i++) path[i] = 1;
        load(16);
        do_start();
        wait_done(200);
        finish_run("edge_x");
        chk("edge_x_err", int'(err), 1);
        chk("edge_x_count", int'(step_count), 15);
        chk("edge_x_x", int'(out_x), 15);

        // Round trip then a step to x=-1.
        path[0] = 0; path[1] = 1; path[2] = 2; path[3] = 3; path[4] = 2;
        load(5);
        do_start();
        chk("model_loop_n", exp_n, 4);
        wait_done(100);
        finish_run("loop");
        chk("loop_err", int'(err), 1);

        // 260 alternating moves: the step counter must saturate, not wrap.
        for (int i = 0; i < 260; i++) path[i] = (i % 2 == 0) ? 1 : 2;
        load(260);
        do_start();
        wait_done(2000);
        finish_run("sat");
        chk("sat_count", int'(step_count), SMAX);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
